// File: rtl/rio_pkg.sv
// Shared SRIO logical-layer definitions: packet types, doorbell INFO codes,
// header field positions and the doorbell initiator state encoding.
package rio_pkg;

    localparam logic [3:0] FTYPE_NREAD  = 4'h2;
    localparam logic [3:0] FTYPE_NWRITE = 4'h5;
    localparam logic [3:0] FTYPE_SWRITE = 4'h6;
    localparam logic [3:0] FTYPE_DOORB  = 4'hA;
    localparam logic [3:0] FTYPE_MESSG  = 4'hB;
    localparam logic [3:0] FTYPE_RESP   = 4'hD;

    localparam logic [15:0] DB_INFO_READY    = 16'h0100;
    localparam logic [15:0] DB_INFO_NOTREADY = 16'h01FF;

    localparam int unsigned HDR_TID_HI   = 63;
    localparam int unsigned HDR_TID_LO   = 56;
    localparam int unsigned HDR_FTYPE_HI = 55;
    localparam int unsigned HDR_FTYPE_LO = 52;
    localparam int unsigned HDR_TTYPE_HI = 51;
    localparam int unsigned HDR_TTYPE_LO = 48;
    localparam int unsigned HDR_INFO_HI  = 31;
    localparam int unsigned HDR_INFO_LO  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } db_state_t;

    typedef struct packed {
        logic [7:0]  tid;
        logic [3:0]  ftype;
        logic [3:0]  ttype;
        logic        rsv_a;
        logic [1:0]  prio;
        logic        crf;
        logic [11:0] rsv_b;
        logic [15:0] info;
        logic [15:0] rsv_c;
    } rio_hdr_t;

    // Single-beat DOORBELL request header
    function automatic rio_hdr_t db_hdr(input logic [7:0] tid, input logic [15:0] info);
        rio_hdr_t h;
        h       = '0;
        h.tid   = tid;
        h.ftype = FTYPE_DOORB;
        h.prio  = 2'h1;
        h.info  = info;
        return h;
    endfunction

endpackage

// File: rtl/db_req_timer.sv
// Clearable free-running up-counter with terminal-count compare; shared by
// the reply timeout and the retry back-off gap.
module db_req_timer #(
    parameter int unsigned W = 8
) (
    input  logic         log_clk,
    input  logic         log_rst,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         hit_c
);

    logic [W-1:0] count_q;

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + W'(1);
        end
    end

    assign hit_c = (count_q == limit);

endmodule

// File: rtl/db_req.sv
// Doorbell initiator: sends a DOORBELL request on ireq, decodes the target's
// reply on iresp, and retries after a back-off gap on not-ready or timeout.
module db_req
    import rio_pkg::*;
#(
    parameter int unsigned RETRY_MAX   = 8,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned RETRY_GAP   = 256
) (
    input  logic        log_clk,
    input  logic        log_rst,
    input  logic [15:0] src_id,
    input  logic [15:0] des_id,
    input  logic        db_start,
    input  logic [15:0] db_info,
    input  logic        ireq_tready_in,
    output logic        ireq_tvalid_o,
    output logic        ireq_tlast_o,
    output logic [63:0] ireq_tdata_o,
    output logic [7:0]  ireq_tkeep_o,
    output logic [31:0] ireq_tuser_o,
    input  logic        iresp_tvalid_in,
    output logic        iresp_tready_o,
    input  logic        iresp_tlast_in,
    input  logic [63:0] iresp_tdata_in,
    input  logic [7:0]  iresp_tkeep_in,
    input  logic [31:0] iresp_tuser_in,
    output logic        busy_o,
    output logic        ed_ready_o,
    output logic        done_o,
    output logic        fail_o
);

    localparam int unsigned TMR_MAX = (TIMEOUT_CYC > RETRY_GAP) ? TIMEOUT_CYC : RETRY_GAP;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;
    localparam int unsigned ATT_W   = $clog2(RETRY_MAX) + 1;

    db_state_t        state_q, state_d;
    logic [ATT_W-1:0] attempt_q, attempt_d;
    logic [7:0]       tid_q, tid_out_q;
    logic [15:0]      db_info_q;
    logic             first_q;
    logic             done_d, fail_d, ed_ready_d, load_d;
    logic             accept_c, rsp_match_c, rsp_ready_c, rsp_nready_c;
    logic             tmr_hit_c, tmr_clr_c;
    logic [TMR_W-1:0] tmr_limit_c;
    logic [15:0]      load_info_c;
    logic             unused_bits;

    assign iresp_tready_o = 1'b1;
    assign accept_c       = ireq_tvalid_o & ireq_tready_in;

    // Only the first beat of a response carries a header worth decoding
    assign rsp_match_c  = iresp_tvalid_in && first_q && (state_q == ST_WAIT)
                       && (iresp_tdata_in[HDR_FTYPE_HI:HDR_FTYPE_LO] == FTYPE_DOORB)
                       && (iresp_tdata_in[HDR_TID_HI:HDR_TID_LO] == tid_out_q);
    assign rsp_ready_c  = rsp_match_c && (iresp_tdata_in[HDR_INFO_HI:HDR_INFO_LO] == DB_INFO_READY);
    assign rsp_nready_c = rsp_match_c && (iresp_tdata_in[HDR_INFO_HI:HDR_INFO_LO] == DB_INFO_NOTREADY);

    assign unused_bits = ^{iresp_tkeep_in, iresp_tuser_in,
                           iresp_tdata_in[HDR_TTYPE_HI:32], iresp_tdata_in[15:0]};

    assign tmr_clr_c   = (state_d != state_q);
    assign tmr_limit_c = (state_q == ST_GAP) ? TMR_W'(RETRY_GAP - 1) : TMR_W'(TIMEOUT_CYC - 1);
    assign load_info_c = (state_q == ST_IDLE) ? db_info : db_info_q;

    db_req_timer #(
        .W (TMR_W)
    ) u_timer (
        .log_clk (log_clk),
        .log_rst (log_rst),
        .clr     (tmr_clr_c),
        .limit   (tmr_limit_c),
        .hit_c   (tmr_hit_c)
    );

    // Next-state and pulse decode; a matching reply outranks the timeout
    always_comb begin
        state_d    = state_q;
        attempt_d  = attempt_q;
        done_d     = 1'b0;
        fail_d     = 1'b0;
        ed_ready_d = ed_ready_o;
        load_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (db_start) begin
                    state_d    = ST_SEND;
                    attempt_d  = '0;
                    ed_ready_d = 1'b0;
                    load_d     = 1'b1;
                end
            end
            ST_SEND: begin
                if (accept_c) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rsp_ready_c) begin
                    state_d    = ST_IDLE;
                    ed_ready_d = 1'b1;
                    done_d     = 1'b1;
                end else if (rsp_nready_c || tmr_hit_c) begin
                    if (attempt_q == ATT_W'(RETRY_MAX - 1)) begin
                        state_d = ST_IDLE;
                        fail_d  = 1'b1;
                    end else begin
                        state_d   = ST_GAP;
                        attempt_d = attempt_q + ATT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (tmr_hit_c) begin
                    state_d = ST_SEND;
                    load_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            state_q    <= ST_IDLE;
            attempt_q  <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            fail_o     <= 1'b0;
            ed_ready_o <= 1'b0;
            db_info_q  <= '0;
            tid_q      <= '0;
            tid_out_q  <= '0;
            first_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            attempt_q  <= attempt_d;
            busy_o     <= (state_d != ST_IDLE);
            done_o     <= done_d;
            fail_o     <= fail_d;
            ed_ready_o <= ed_ready_d;
            if (db_start && (state_q == ST_IDLE)) begin
                db_info_q <= db_info;
            end
            if (accept_c) begin
                tid_q     <= tid_q + 8'd1;
                tid_out_q <= tid_q;
            end
            if (iresp_tvalid_in) begin
                first_q <= iresp_tlast_in;
            end
        end
    end

    // Request beat: loaded on entry to SEND, held until accepted
    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            ireq_tvalid_o <= 1'b0;
            ireq_tlast_o  <= 1'b0;
            ireq_tdata_o  <= '0;
            ireq_tkeep_o  <= '0;
            ireq_tuser_o  <= '0;
        end else if (load_d) begin
            ireq_tvalid_o <= 1'b1;
            ireq_tlast_o  <= 1'b1;
            ireq_tdata_o  <= db_hdr(tid_q, load_info_c);
            ireq_tkeep_o  <= 8'hFF;
            ireq_tuser_o  <= {src_id, des_id};
        end else if (accept_c) begin
            ireq_tvalid_o <= 1'b0;
            ireq_tlast_o  <= 1'b0;
            ireq_tdata_o  <= '0;
            ireq_tkeep_o  <= '0;
            ireq_tuser_o  <= '0;
        end
    end

endmodule

// File: tb/tb_db_req.sv
// Self-checking bench for db_req: table-driven first requests, directed retry,
// timeout, stall, reset and tid-wrap sequences, then randomized operations.
module tb_db_req;

    localparam int unsigned RM  = 3;
    localparam int unsigned TO  = 40;
    localparam int unsigned GAP = 12;

    localparam int K_READY  = 0;
    localparam int K_NREADY = 1;
    localparam int K_NONE   = 2;
    localparam int K_JUNK   = 3;
    localparam int K_EDGE   = 4;

    logic        log_clk = 1'b0;
    logic        log_rst = 1'b1;
    logic [15:0] src_id = 16'h0;
    logic [15:0] des_id = 16'h0;
    logic        db_start = 1'b0;
    logic [15:0] db_info = 16'h0;
    logic        ireq_tready_in = 1'b0;
    logic        ireq_tvalid_o;
    logic        ireq_tlast_o;
    logic [63:0] ireq_tdata_o;
    logic [7:0]  ireq_tkeep_o;
    logic [31:0] ireq_tuser_o;
    logic        iresp_tvalid_in = 1'b0;
    logic        iresp_tready_o;
    logic        iresp_tlast_in = 1'b0;
    logic [63:0] iresp_tdata_in = 64'h0;
    logic [7:0]  iresp_tkeep_in = 8'h0;
    logic [31:0] iresp_tuser_in = 32'h0;
    logic        busy_o;
    logic        ed_ready_o;
    logic        done_o;
    logic        fail_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0, fail_cnt = 0, exp_done = 0, exp_fail = 0;
    int m_tid = 0;
    int kinds[RM];
    int stall_pct = 0, hold_low = 0, fix_d = -1;
    bit poke_start = 1'b0;
    int acc0_cyc = 0, fail_cyc = 0;
    logic [63:0] first_data;
    logic [31:0] first_user;
    bit          stall_prev = 1'b0;
    logic [63:0] snap_data;
    logic [31:0] snap_user;

    typedef struct {
        logic [15:0] info;
        logic [15:0] src;
        logic [15:0] des;
        logic [63:0] exp_data;
    } vec_t;
    vec_t tbl[4];

    db_req #(
        .RETRY_MAX   (RM),
        .TIMEOUT_CYC (TO),
        .RETRY_GAP   (GAP)
    ) dut (
        .log_clk         (log_clk),
        .log_rst         (log_rst),
        .src_id          (src_id),
        .des_id          (des_id),
        .db_start        (db_start),
        .db_info         (db_info),
        .ireq_tready_in  (ireq_tready_in),
        .ireq_tvalid_o   (ireq_tvalid_o),
        .ireq_tlast_o    (ireq_tlast_o),
        .ireq_tdata_o    (ireq_tdata_o),
        .ireq_tkeep_o    (ireq_tkeep_o),
        .ireq_tuser_o    (ireq_tuser_o),
        .iresp_tvalid_in (iresp_tvalid_in),
        .iresp_tready_o  (iresp_tready_o),
        .iresp_tlast_in  (iresp_tlast_in),
        .iresp_tdata_in  (iresp_tdata_in),
        .iresp_tkeep_in  (iresp_tkeep_in),
        .iresp_tuser_in  (iresp_tuser_in),
        .busy_o          (busy_o),
        .ed_ready_o      (ed_ready_o),
        .done_o          (done_o),
        .fail_o          (fail_o)
    );

    always #5 log_clk = ~log_clk;
    always @(posedge log_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expire(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Request header as the bench understands it: plain field arithmetic
    function automatic logic [63:0] exp_hdr(input int tid, input logic [15:0] info);
        return (64'(tid % 256) << 56) | (64'hA << 52) | (64'h1 << 45) | (64'(info) << 16);
    endfunction

    task automatic step();
        @(posedge log_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_beat(input int tid, input logic [3:0] ftype, input logic [15:0] info,
                             input logic last);
        iresp_tvalid_in = 1'b1;
        iresp_tlast_in  = last;
        iresp_tdata_in  = (64'(tid % 256) << 56) | (64'(ftype) << 52) | (64'(info) << 16)
                        | 64'($urandom_range(0, 65535));
        iresp_tuser_in  = {des_id, src_id};
        iresp_tkeep_in  = 8'hFF;
        step();
        iresp_tvalid_in = 1'b0;
        iresp_tlast_in  = 1'b0;
    endtask

    // Beats that must all be dropped while a request with this tid is outstanding
    task automatic junk_beats(input int tid);
        send_beat(tid + 1, 4'hA, 16'h0100, 1'b1);
        send_beat(tid, 4'h5, 16'h0000, 1'b0);
        send_beat(tid, 4'hA, 16'h0100, 1'b1);
        send_beat(tid, 4'hA, 16'h0055, 1'b1);
        send_beat(tid, 4'hD, 16'h0100, 1'b1);
        chk("junk_ignored", 128'({busy_o, done_o, ed_ready_o}), 128'(3'b100));
    endtask

    // One doorbell operation; kinds[] scripts the reply for each attempt
    task automatic run_op(input logic [15:0] info);
        int  d, cnt, tgt, kd, hold, out_tid;
        bit  acc, last;
        db_info  = info;
        db_start = 1'b1;
        step();
        db_start = 1'b0;
        db_info  = 16'($urandom);
        chk("start_tvalid", 128'(ireq_tvalid_o), 128'(1'b1));
        chk("start_busy_edready", 128'({busy_o, ed_ready_o}), 128'(2'b10));
        hold = hold_low;
        for (int att = 0; att < int'(RM); att++) begin
            cnt = 0;
            acc = 1'b0;
            while (!acc) begin
                if (cnt > 400) begin
                    expire("req_accept");
                    return;
                end
                if (hold > 0) begin
                    ireq_tready_in = 1'b0;
                    hold--;
                end else begin
                    ireq_tready_in = ($urandom_range(0, 99) >= stall_pct);
                end
                acc = ireq_tvalid_o && ireq_tready_in;
                if (acc) begin
                    chk("req_tdata", 128'(ireq_tdata_o), 128'(exp_hdr(m_tid, info)));
                    chk("req_tuser", 128'(ireq_tuser_o), 128'({src_id, des_id}));
                    chk("req_tkeep_tlast", 128'({ireq_tkeep_o, ireq_tlast_o}), 128'({8'hFF, 1'b1}));
                    if (att == 0) begin
                        first_data = ireq_tdata_o;
                        first_user = ireq_tuser_o;
                    end
                end
                step();
                cnt++;
            end
            ireq_tready_in = 1'b0;
            if (att == 0) acc0_cyc = cyc;
            out_tid = m_tid;
            m_tid   = (m_tid + 1) % 256;
            chk("tvalid_after_accept", 128'(ireq_tvalid_o), 128'(1'b0));
            last = (att == int'(RM) - 1);
            kd   = kinds[att];
            d    = (fix_d >= 0) ? fix_d : int'($urandom_range(0, 4));
            if (kd == K_READY || kd == K_JUNK || kd == K_EDGE) begin
                if (kd == K_JUNK) junk_beats(out_tid);
                if (kd == K_EDGE) d = int'(TO) - 1;
                if (poke_start && d > 0) begin
                    db_info  = 16'h2222;
                    db_start = 1'b1;
                    step();
                    db_start = 1'b0;
                    chk("busy_start_ignored", 128'({ireq_tvalid_o, busy_o}), 128'(2'b01));
                    d--;
                end
                idle(d);
                send_beat(out_tid, 4'hA, 16'h0100, 1'b1);
                chk("done_pulse", 128'({done_o, fail_o, ed_ready_o, busy_o}), 128'(4'b1010));
                exp_done++;
                step();
                chk("done_clear", 128'({done_o, ireq_tvalid_o, ed_ready_o}), 128'(3'b001));
                return;
            end
            if (kd == K_NREADY) begin
                idle(d);
                send_beat(out_tid, 4'hA, 16'h01FF, 1'b1);
                cnt = d + 1;
                tgt = d + 1;
            end else begin
                cnt = 0;
                tgt = int'(TO);
            end
            if (!last) tgt += int'(GAP);
            while (!(last ? fail_o : ireq_tvalid_o)) begin
                if (done_o || cnt > tgt + 5) begin
                    expire("outcome_wait");
                    return;
                end
                step();
                cnt++;
            end
            chk(last ? "fail_timing" : "retry_timing", 128'(cnt), 128'(tgt));
            if (last) begin
                fail_cyc = cyc;
                chk("fail_pulse", 128'({done_o, fail_o, ed_ready_o, busy_o}), 128'(4'b0100));
                exp_fail++;
                step();
                chk("fail_clear", 128'({fail_o, busy_o}), 128'(2'b00));
                return;
            end
        end
    endtask

    // Payload must hold across every stalled cycle; count completion pulses
    always @(negedge log_clk) begin
        if (log_rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("stall_hold", 128'({ireq_tvalid_o, ireq_tdata_o, ireq_tuser_o}),
                    128'({1'b1, snap_data, snap_user}));
            stall_prev = ireq_tvalid_o && !ireq_tready_in;
            snap_data  = ireq_tdata_o;
            snap_user  = ireq_tuser_o;
            if (done_o) done_cnt++;
            if (fail_o) fail_cnt++;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'h0100, 16'h1234, 16'h5678, 64'h00A0_2000_0100_0000};
        tbl[1] = '{16'hBEEF, 16'h0001, 16'hFFFE, 64'h01A0_2000_BEEF_0000};
        tbl[2] = '{16'h0000, 16'hA5A5, 16'h5A5A, 64'h02A0_2000_0000_0000};
        tbl[3] = '{16'hFFFF, 16'h00FF, 16'hFF00, 64'h03A0_2000_FFFF_0000};

        idle(2);
        chk("reset_ctrl", 128'({ireq_tvalid_o, ireq_tlast_o, ireq_tkeep_o, busy_o, ed_ready_o,
                                done_o, fail_o, iresp_tready_o}),
            128'({1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
        log_rst = 1'b0;
        step();
        chk("reset_payload", 128'({ireq_tdata_o, ireq_tuser_o}), 128'(0));

        // Table: single-attempt operations, reply five cycles after acceptance
        stall_pct = 0;
        fix_d     = 4;
        kinds[0]  = K_READY;
        for (int i = 0; i < 4; i++) begin
            src_id = tbl[i].src;
            des_id = tbl[i].des;
            run_op(tbl[i].info);
            chk("tbl_tdata", 128'(first_data), 128'(tbl[i].exp_data));
            chk("tbl_tuser", 128'(first_user), 128'({tbl[i].src, tbl[i].des}));
        end
        fix_d = -1;

        // Two not-ready replies, then ready on the third attempt
        kinds[0] = K_NREADY;
        kinds[1] = K_NREADY;
        kinds[2] = K_READY;
        run_op(16'h0100);

        // No reply at all: three timeouts then failure
        kinds[0] = K_NONE;
        kinds[1] = K_NONE;
        kinds[2] = K_NONE;
        run_op(16'h4242);
        chk("fail_total_time", 128'(fail_cyc - acc0_cyc), 128'(3 * TO + 2 * GAP + 2));
        chk("fail_edready", 128'(ed_ready_o), 128'(1'b0));

        // Long ready stall, then dropped junk beats before the real reply
        hold_low = 20;
        kinds[0] = K_JUNK;
        run_op(16'h0BAD);
        hold_low = 0;

        // Reply on the timeout cycle wins; db_start while busy is ignored
        poke_start = 1'b1;
        kinds[0]   = K_EDGE;
        run_op(16'h7777);
        poke_start = 1'b0;
        idle(2);
        chk("no_extra_request", 128'({ireq_tvalid_o, busy_o}), 128'(2'b00));

        // Reset while waiting for a reply
        db_info  = 16'h3333;
        db_start = 1'b1;
        step();
        db_start       = 1'b0;
        ireq_tready_in = 1'b1;
        step();
        ireq_tready_in = 1'b0;
        idle(3);
        log_rst = 1'b1;
        #1;
        chk("rst_async", 128'({ireq_tvalid_o, ireq_tdata_o, busy_o, ed_ready_o, done_o, fail_o,
                               iresp_tready_o}),
            128'({1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
        step();
        log_rst = 1'b0;
        step();
        chk("rst_no_pulse", 128'({done_cnt, fail_cnt}), 128'({exp_done, exp_fail}));
        m_tid = 0;

        // tid wrap after 256 requests
        kinds[0] = K_READY;
        for (int i = 0; i < 256; i++) run_op(16'($urandom));
        chk("tid_ff", 128'(first_data[63:56]), 128'(8'hFF));
        run_op(16'h0100);
        chk("tid_wrap", 128'(first_data[63:56]), 128'(8'h00));

        // Randomized operations against the attempt-level model
        stall_pct = 30;
        for (int n = 0; n < 60; n++) begin
            for (int a = 0; a < int'(RM); a++) kinds[a] = int'($urandom_range(0, 4));
            poke_start = ($urandom_range(0, 3) == 0);
            src_id     = 16'($urandom);
            des_id     = 16'($urandom);
            run_op(16'($urandom));
        end
        poke_start = 1'b0;
        idle(3);
        chk("done_count", 128'(done_cnt), 128'(exp_done));
        chk("fail_count", 128'(fail_cnt), 128'(exp_fail));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/db_req.md
# db_req

Doorbell initiator for the endpoint-readiness handshake: on request it sends a DOORBELL packet on the AXI-Stream initiator request channel (ireq). It then decodes the target's DOORBELL reply on the initiator response channel (iresp). A "not ready" reply or a timeout triggers a retry after a back-off gap, up to a retry limit. It is the requesting end of the doorbell readiness exchange and sits between local control logic and the SRIO logical-layer initiator port, clocked by log_clk.

## Interface
- RETRY_MAX, 8: total send attempts before failure (≥1)
- TIMEOUT_CYC, 1024: cycles waited for a reply after request acceptance
- RETRY_GAP, 256: back-off cycles between a failed attempt and the next send
- log_clk  in  1  logic clock
- log_rst  in  1  reset; asynchronous, active-high
- src_id  in  16  own device ID
- des_id  in  16  target device ID
- db_start  in  1  one-cycle start pulse; honoured only in IDLE
- db_info  in  16  INFO field placed in the request; sampled on accepted db_start
- ireq_tready_in  in  1  ireq ready
- ireq_tvalid_o  out  1  ireq valid
- ireq_tlast_o  out  1  always 1 with valid (single beat)
- ireq_tdata_o  out  64  request header
- ireq_tkeep_o  out  8  8'hFF with valid
- ireq_tuser_o  out  32  {src_id, des_id} with valid
- iresp_tvalid_in  in  1  response valid
- iresp_tready_o  out  1  constant 1
- iresp_tlast_in  in  1  response last
- iresp_tdata_in  in  64  response header/data
- iresp_tkeep_in  in  8  unused
- iresp_tuser_in  in  32  [31:16] responder source ID
- busy_o  out  1  high in every state except IDLE
- ed_ready_o  out  1  sticky: target reported ready; cleared on accepted db_start
- done_o  out  1  one-cycle pulse on successful handshake
- fail_o  out  1  one-cycle pulse when retries are exhausted

## Operation
- Request header: {tid[7:0], 4'hA, 4'b0, 1'b0, 2'h1, 1'b0, 12'b0, db_info_q[15:0], 16'h0}.
- tid: 8-bit counter. It increments on each ireq acceptance and wraps 8'hFF→8'h00.
- Response decode uses first beats only. First-beat flag is set on reset and after any beat with tlast; it clears on a beat without tlast.
- A response matches when first beat, tdata[55:52]==4'hA, tdata[63:56]==tid of the outstanding request, and state is WAIT.
- Matched INFO tdata[31:16]:
  - 16'h0100 → ready
  - 16'h01FF → not-ready
  - any other value → ignored; wait continues
- Non-matching beats are consumed and dropped.
- FSM:
  - IDLE: on db_start → SEND; latch db_info, clear ed_ready_o, attempt counter=0.
  - SEND: hold ireq_tvalid_o=1 with stable payload until ireq_tready_in. On acceptance → WAIT, timer=0.
  - WAIT, ready match → IDLE; ed_ready_o=1, done_o pulse.
  - WAIT, not-ready match or timer==TIMEOUT_CYC-1: if attempt==RETRY_MAX-1 → IDLE with fail_o pulse; else attempt+1 → GAP, timer=0.
  - GAP: when timer==RETRY_GAP-1 → SEND.
- Simultaneous events:
  - Matching reply on the timeout cycle: the reply wins.
  - db_start outside IDLE: ignored.

## Timing
- All outputs are registered.
- Reset values: every output 0 except iresp_tready_o=1; tid=0; state IDLE.
- Reset mid-operation aborts immediately. The request in flight is dropped without a done_o or fail_o pulse.
- db_start at cycle N → ireq_tvalid_o=1 at N+1.
- Accepted ready reply at cycle M → ed_ready_o=1, done_o=1, busy_o=0 at M+1.
- Timeout: reply-free WAIT lasts exactly TIMEOUT_CYC cycles after the acceptance cycle.
- GAP lasts RETRY_GAP cycles. The next ireq_tvalid_o rises the cycle after GAP ends.
- ireq_tvalid_o never deasserts without acceptance; AXI-Stream rules apply.

## Structure
- Shared package rio_pkg holds:
  - FTYPE constants: NREAD 4'h2, NWRITE 4'h5, SWRITE 4'h6, DOORB 4'hA, MESSG 4'hB, RESP 4'hD
  - DB_INFO_READY 16'h0100, DB_INFO_NOTREADY 16'h01FF
  - header field bit positions: tid 63:56, ftype 55:52, ttype 51:48, info 31:16
  - FSM state enum
- One sub-module: db_req_timer. It is a clearable up-counter with a terminal-count compare, reused for timeout and gap.

## Test plan
- db_start with db_info=16'h0100, tready=1, reply INFO 16'h0100 tid 8'h00 five cycles later → one request with tdata=64'h00A0_2000_0100_0000 and tuser={src_id,des_id}; ed_ready_o=1; one done_o pulse.
- Reply 16'h01FF twice, then 16'h0100 → three requests with tid 00, 01, 02 spaced ≥RETRY_GAP cycles apart; done_o once.
- No reply with RETRY_MAX=3 → three requests, then fail_o pulse at 3·TIMEOUT_CYC+2·RETRY_GAP cycles after the first acceptance, plus send latencies; ed_ready_o=0.
- ireq_tready_in held low for 20 cycles → tvalid and payload stable throughout; a wrong-tid reply during WAIT is ignored.
- Reply arriving on the timeout cycle → success. db_start during busy → ignored. log_rst asserted in WAIT → all outputs reset with no pulse.
- tid wrap: preload via 256 attempts → request after tid 8'hFF carries 8'h00.
